// File: rtl/bubble_data_serializer_pkg.sv
// Shared definitions for the bubble data serializer: access-type encodings,
// default buffer geometry and the serializer FSM state type.
package bubble_pkg;

  typedef enum logic [2:0] {
    ACC_RST  = 3'b000,
    ACC_STBY = 3'b001,
    ACC_IDLE = 3'b100,
    ACC_SWAP = 3'b101,
    ACC_BOOT = 3'b110,
    ACC_USER = 3'b111
  } acctype_e;

  localparam int          DEF_BOOT_BITS = 4106;
  localparam int          DEF_USER_BITS = 584;
  localparam logic [10:0] DEF_BOOT_BASE = 11'h000;
  localparam logic [10:0] DEF_USER_BASE = 11'h600;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_WAIT   = 2'd2,
    ST_EMIT   = 2'd3
  } state_e;

endpackage

// File: rtl/bubble_data_serializer_if.sv
// Strobe/control inputs, buffer read port and serial outputs of the serializer.
// The slave side is the serializer; the master side is its environment.
interface bubble_data_serializer_if;
  logic [2:0]  ACCTYPE;
  logic [12:0] BOUTCYCLENUM;
  logic        nBOUTCLKEN;
  logic        nNOBUBBLE;
  logic [10:0] BUFADDR;
  logic        BUFRDEN;
  logic [7:0]  BUFDATA;
  logic        BOUT;
  logic        BOUTVALID;
  logic        OVERRUN;

  modport slave (
    input  ACCTYPE, BOUTCYCLENUM, nBOUTCLKEN, nNOBUBBLE, BUFDATA,
    output BUFADDR, BUFRDEN, BOUT, BOUTVALID, OVERRUN
  );

  modport master (
    output ACCTYPE, BOUTCYCLENUM, nBOUTCLKEN, nNOBUBBLE, BUFDATA,
    input  BUFADDR, BUFRDEN, BOUT, BOUTVALID, OVERRUN
  );
endinterface

// File: rtl/bubble_data_serializer_byte_cache.sv
// One-byte cache of the last buffer byte fetched, tagged with its address and
// access type; dropped whenever the live access type leaves the cached mode.
module bubble_byte_cache (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  i_acctype,
  input  logic [10:0] i_lookup_addr,
  output logic        o_hit,
  input  logic        i_load,
  input  logic [10:0] i_load_addr,
  input  logic [2:0]  i_load_mode,
  input  logic [7:0]  i_load_data,
  output logic [7:0]  o_data
);

  logic [7:0]  r_data;
  logic [10:0] r_addr;
  logic [2:0]  r_mode;
  logic        r_valid;
  logic        w_inval;

  assign w_inval = ~i_acctype[1] | (i_acctype != r_mode);
  // Invalidation wins over a tag match in the same cycle.
  assign o_hit   = r_valid & ~w_inval & (r_addr == i_lookup_addr);
  assign o_data  = r_data;

  // NOTE: a single byte of storage, so the data is reset along with its tag
  // rather than left undefined as a larger memory array would be.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= 8'h00;
      r_addr  <= 11'h000;
      r_mode  <= 3'b000;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_load_data;
      r_addr  <= i_load_addr;
      r_mode  <= i_load_mode;
      r_valid <= i_acctype[1] & (i_acctype == i_load_mode);
    end else if (w_inval) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bubble_data_serializer.sv
// Turns each output-clock strobe into one serial bubble bit with a fixed
// three-cycle latency, fetching buffer bytes through a one-byte cache.
module bubble_data_serializer
  import bubble_pkg::*;
#(
  parameter logic [10:0] BOOT_BASE = DEF_BOOT_BASE,
  parameter logic [10:0] USER_BASE = DEF_USER_BASE,
  parameter int          BOOT_BITS = DEF_BOOT_BITS,
  parameter int          USER_BITS = DEF_USER_BITS
) (
  input  logic                     MCLK,
  input  logic                     RESET,
  bubble_data_serializer_if.slave  bus
);

  state_e      r_state;
  logic [12:0] r_idx;
  logic [2:0]  r_mode;
  logic [10:0] r_addr;
  logic        r_forcenb;
  logic        r_fetch;
  logic        r_bout;
  logic        r_boutvalid;
  logic        r_bufrden;
  logic [10:0] r_bufaddr;
  logic        r_overrun;

  logic [13:0] w_limit;
  logic [10:0] w_base;
  logic [10:0] w_addr;
  logic        w_forcenb;
  logic        w_hit;
  logic        w_fetch;
  logic        w_strobe;
  logic        w_load;
  logic [7:0]  w_cache_data;

  always_comb begin
    w_limit = 14'd0;
    if (bus.ACCTYPE == ACC_BOOT)      w_limit = 14'(BOOT_BITS);
    else if (bus.ACCTYPE == ACC_USER) w_limit = 14'(USER_BITS);
  end

  assign w_base    = bus.ACCTYPE[0] ? USER_BASE : BOOT_BASE;
  assign w_addr    = w_base + {1'b0, bus.BOUTCYCLENUM[12:3]};
  assign w_forcenb = ~bus.nNOBUBBLE | ~bus.ACCTYPE[1] |
                     ({1'b0, bus.BOUTCYCLENUM} >= w_limit);
  assign w_fetch   = ~w_forcenb & ~w_hit;
  assign w_strobe  = ~bus.nBOUTCLKEN;
  assign w_load    = (r_state == ST_WAIT) & r_fetch;

  bubble_byte_cache u_cache (
    .clk           (MCLK),
    .rst           (RESET),
    .i_acctype     (bus.ACCTYPE),
    .i_lookup_addr (w_addr),
    .o_hit         (w_hit),
    .i_load        (w_load),
    .i_load_addr   (r_addr),
    .i_load_mode   (r_mode),
    .i_load_data   (bus.BUFDATA),
    .o_data        (w_cache_data)
  );

  // The lookup is resolved on the strobe edge so that BUFRDEN/BUFADDR are
  // registered and present for exactly the LOOKUP cycle.
  // NOTE: every state and output register below uses <= so all of them
  // update together from the same pre-edge values.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_idx       <= 13'd0;
      r_mode      <= 3'b000;
      r_addr      <= 11'h000;
      r_forcenb   <= 1'b0;
      r_fetch     <= 1'b0;
      r_bout      <= 1'b1;
      r_boutvalid <= 1'b0;
      r_bufrden   <= 1'b0;
      r_bufaddr   <= 11'h000;
      r_overrun   <= 1'b0;
    end else begin
      r_bufrden   <= 1'b0;
      r_boutvalid <= 1'b0;
      if (w_strobe && (r_state != ST_IDLE)) r_overrun <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_strobe) begin
            r_idx     <= bus.BOUTCYCLENUM;
            r_mode    <= bus.ACCTYPE;
            r_addr    <= w_addr;
            r_forcenb <= w_forcenb;
            r_fetch   <= w_fetch;
            if (w_fetch) begin
              r_bufrden <= 1'b1;
              r_bufaddr <= w_addr;
            end
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: r_state <= ST_WAIT;
        ST_WAIT:   r_state <= ST_EMIT;
        ST_EMIT: begin
          // Byte MSB holds the lowest bit index; a set data bit is a bubble.
          r_bout      <= r_forcenb | ~w_cache_data[~r_idx[2:0]];
          r_boutvalid <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.BOUT      = r_bout;
  assign bus.BOUTVALID = r_boutvalid;
  assign bus.BUFRDEN   = r_bufrden;
  assign bus.BUFADDR   = r_bufaddr;
  assign bus.OVERRUN   = r_overrun;

endmodule

// File: tb/tb_bubble_data_serializer.sv
// Directed, table-driven bench for bubble_data_serializer with a behavioural
// 1-cycle-latency buffer model.
module tb_bubble_data_serializer;

  logic MCLK;
  logic RESET;

  bubble_data_serializer_if bus ();

  bubble_data_serializer dut (
    .MCLK  (MCLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  logic [7:0] mem [0:2047];
  always @(posedge MCLK)
    if (bus.BUFRDEN) bus.BUFDATA <= mem[bus.BUFADDR];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  acc;
    logic [12:0] idx;
    logic        nob;
    logic        exp_bout;
    logic        exp_rd;
    logic [10:0] exp_addr;
  } vec_t;

  // Strobe at edge T, sample reads in the three cycles after it, expect the
  // BOUTVALID pulse and new BOUT right after edge T+3.
  task automatic run_vec(input string tag, input vec_t v);
    int          rd;
    logic [10:0] addr;
    logic        early;
    rd = 0; addr = 11'h000; early = 1'b0;
    @(negedge MCLK);
    bus.ACCTYPE      = v.acc;
    bus.BOUTCYCLENUM = v.idx;
    bus.nNOBUBBLE    = v.nob;
    bus.nBOUTCLKEN   = 1'b0;
    @(negedge MCLK);
    bus.nBOUTCLKEN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (bus.BUFRDEN) begin
        rd++;
        addr = bus.BUFADDR;
      end
      if (bus.BOUTVALID) early = 1'b1;
      @(negedge MCLK);
    end
    check({tag, " boutvalid"}, bus.BOUTVALID, 1);
    check({tag, " bout"}, bus.BOUT, v.exp_bout);
    check({tag, " early valid"}, early, 0);
    check({tag, " reads"}, rd, v.exp_rd ? 1 : 0);
    if (v.exp_rd) check({tag, " bufaddr"}, addr, v.exp_addr);
    @(negedge MCLK);
    check({tag, " valid width"}, bus.BOUTVALID, 0);
    repeat (15) @(negedge MCLK);
  endtask

  vec_t vecs [20];
  int   pulses;
  int   pulse_at;

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = 8'h00;
    mem[11'h600] = 8'hA5;
    mem[11'h201] = 8'h40;
    mem[11'h000] = 8'h80;
    mem[11'h648] = 8'h01;
    mem[11'h602] = 8'hFF;
    mem[11'h002] = 8'h00;
    mem[11'h603] = 8'h00;

    //          acc     idx   nob  bout rd  addr
    vecs[0]  = '{3'b111, 13'd0,    1, 0, 1, 11'h600};
    vecs[1]  = '{3'b111, 13'd1,    1, 1, 0, 11'h000};
    vecs[2]  = '{3'b111, 13'd2,    1, 0, 0, 11'h000};
    vecs[3]  = '{3'b111, 13'd3,    1, 1, 0, 11'h000};
    vecs[4]  = '{3'b111, 13'd4,    1, 1, 0, 11'h000};
    vecs[5]  = '{3'b111, 13'd5,    1, 0, 0, 11'h000};
    vecs[6]  = '{3'b111, 13'd6,    1, 1, 0, 11'h000};
    vecs[7]  = '{3'b111, 13'd7,    1, 0, 0, 11'h000};
    vecs[8]  = '{3'b110, 13'd4104, 1, 1, 1, 11'h201};
    vecs[9]  = '{3'b110, 13'd4105, 1, 0, 0, 11'h000};
    vecs[10] = '{3'b110, 13'd0,    1, 0, 1, 11'h000};
    vecs[11] = '{3'b110, 13'd4106, 1, 1, 0, 11'h000};
    vecs[12] = '{3'b111, 13'd583,  1, 0, 1, 11'h648};
    vecs[13] = '{3'b111, 13'd584,  1, 1, 0, 11'h000};
    vecs[14] = '{3'b111, 13'd583,  0, 1, 0, 11'h000};
    vecs[15] = '{3'b100, 13'd0,    1, 1, 0, 11'h000};
    vecs[16] = '{3'b111, 13'd583,  1, 0, 1, 11'h648};
    vecs[17] = '{3'b111, 13'd16,   1, 0, 1, 11'h602};
    vecs[18] = '{3'b110, 13'd16,   1, 1, 1, 11'h002};
    vecs[19] = '{3'b111, 13'd17,   1, 0, 1, 11'h602};

    RESET            = 1'b1;
    bus.ACCTYPE      = 3'b000;
    bus.BOUTCYCLENUM = 13'd0;
    bus.nBOUTCLKEN   = 1'b1;
    bus.nNOBUBBLE    = 1'b1;
    repeat (2) @(negedge MCLK);
    check("reset bout", bus.BOUT, 1);
    check("reset boutvalid", bus.BOUTVALID, 0);
    check("reset bufrden", bus.BUFRDEN, 0);
    check("reset bufaddr", bus.BUFADDR, 0);
    check("reset overrun", bus.OVERRUN, 0);
    RESET = 1'b0;
    repeat (3) @(negedge MCLK);

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back strobes: the second is dropped and flags OVERRUN.
    bus.ACCTYPE      = 3'b111;
    bus.BOUTCYCLENUM = 13'd18;
    bus.nNOBUBBLE    = 1'b1;
    bus.nBOUTCLKEN   = 1'b0;
    @(negedge MCLK);
    check("ovr before", bus.OVERRUN, 0);
    bus.BOUTCYCLENUM = 13'd20;
    @(negedge MCLK);
    bus.nBOUTCLKEN = 1'b1;
    check("ovr set", bus.OVERRUN, 1);
    pulses = 0; pulse_at = -1;
    for (int k = 0; k < 10; k++) begin
      if (bus.BOUTVALID) begin
        pulses++;
        if (pulse_at < 0) pulse_at = k;
      end
      if (k == 2) check("ovr bout", bus.BOUT, 0);
      @(negedge MCLK);
    end
    check("ovr pulse count", pulses, 1);
    check("ovr pulse time", pulse_at, 2);
    check("ovr sticky", bus.OVERRUN, 1);

    // Reset between the read and the cache load of a fresh fetch.
    bus.ACCTYPE      = 3'b111;
    bus.BOUTCYCLENUM = 13'd24;
    bus.nBOUTCLKEN   = 1'b0;
    @(negedge MCLK);
    bus.nBOUTCLKEN = 1'b1;
    check("rst fetch rden", bus.BUFRDEN, 1);
    check("rst fetch addr", bus.BUFADDR, 11'h603);
    @(negedge MCLK);
    RESET = 1'b1;
    #1;
    check("rst mid bout", bus.BOUT, 1);
    check("rst mid boutvalid", bus.BOUTVALID, 0);
    check("rst mid bufrden", bus.BUFRDEN, 0);
    check("rst mid bufaddr", bus.BUFADDR, 0);
    check("rst mid overrun", bus.OVERRUN, 0);
    @(negedge MCLK);
    RESET = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.BOUTVALID) pulses++;
      @(negedge MCLK);
    end
    check("rst no emit", pulses, 0);
    run_vec("post reset", '{3'b111, 13'd16, 1'b1, 1'b0, 1'b1, 11'h602});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
